// File: rtl/audio_receive.sv
// audio_receive: I2S capture for the WM8978 ADC path.
//
// Deserialises aud_adcdat MSB first on rising aud_bclk, assembles a left and
// a right word into a stereo pair and offers it through a valid/ready
// handshake. Words are WL bits (16..32) in 32-bit output registers.
//
// Ports:
//   aud_bclk    in   bit clock, only clock, rising edge
//   sys_rst     in   asynchronous active-low reset
//   aud_lrc     in   channel sync: 0 = left, 1 = right
//   aud_adcdat  in   serial ADC data
//   adc_data_l  out  left sample [WL-1:0], upper bits filled (see below)
//   adc_data_r  out  right sample, same packing
//   adc_valid   out  stereo pair available
//   adc_ready   in   pair accepted when adc_valid && adc_ready
//   rx_done     out  one-cycle pulse per completed channel word
//   frame_err   out  one-cycle pulse when a word is cut short by aud_lrc
//   overrun     out  sticky: a completed pair was dropped (cleared by reset)
//
// Build option AUD_RX_SIGN_EXT_EN: when defined, bits [31:WL] of the output
// samples replicate bit WL-1; otherwise they are zero.

module audio_receive #(
  parameter logic [5:0] WL = 6'd32
) (
  input  logic        aud_bclk,
  input  logic        sys_rst,
  input  logic        aud_lrc,
  input  logic        aud_adcdat,
  output logic [31:0] adc_data_l,
  output logic [31:0] adc_data_r,
  output logic        adc_valid,
  input  logic        adc_ready,
  output logic        rx_done,
  output logic        frame_err,
  output logic        overrun
);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  localparam int unsigned WL_I     = 32'(WL);
  localparam logic [5:0]  CNT_IDLE = 6'd63;

  logic        lrc_d0_q, lrc_d0_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;
  chan_e       ch_q, ch_d;
  logic [30:0] shift_q, shift_d;
  logic [31:0] left_hold_q, left_hold_d;
  logic        left_held_q, left_held_d;
  logic [31:0] adc_data_l_q, adc_data_l_d;
  logic [31:0] adc_data_r_q, adc_data_r_d;
  logic        adc_valid_q, adc_valid_d;
  logic        rx_done_q, rx_done_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic        lrc_edge;
  logic [31:0] word;

  // Keep [WL-1:0] of the shifted word and fill the upper bits.
  function automatic logic [31:0] pack_word(input logic [31:0] w);
    logic [31:0] r;
    logic        fill;
`ifdef AUD_RX_SIGN_EXT_EN
    fill = w[WL_I-1];
`else
    fill = 1'b0;
`endif
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = (i < WL_I) ? w[i] : fill;
    end
    return r;
  endfunction

  assign lrc_edge = aud_lrc ^ lrc_d0_q;
  assign word     = {shift_q, aud_adcdat};

  always_comb begin
    lrc_d0_d     = aud_lrc;
    rx_cnt_d     = rx_cnt_q;
    ch_d         = ch_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    left_held_d  = left_held_q;
    adc_data_l_d = adc_data_l_q;
    adc_data_r_d = adc_data_r_q;
    adc_valid_d  = adc_valid_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;

    // Consumer handshake; a pair completing in this same cycle overrides below.
    if (adc_valid_q && adc_ready) begin
      adc_valid_d = 1'b0;
    end

    if (lrc_edge) begin
      // The bit on the sync edge belongs to the I2S one-bit delay slot.
      rx_cnt_d = '0;
      ch_d     = aud_lrc ? CH_RIGHT : CH_LEFT;
      if ((rx_cnt_q != 6'd0) && (rx_cnt_q < WL)) begin
        frame_err_d = 1'b1;
        if (ch_q == CH_LEFT) begin
          left_held_d = 1'b0;
        end
      end
    end else if (rx_cnt_q < WL) begin
      shift_d  = word[30:0];
      rx_cnt_d = rx_cnt_q + 6'd1;
      if (rx_cnt_q == (WL - 6'd1)) begin
        rx_done_d = 1'b1;
        if (ch_q == CH_LEFT) begin
          left_hold_d = pack_word(word);
          left_held_d = 1'b1;
        end else if (left_held_q) begin
          left_held_d = 1'b0;
          if (!adc_valid_q || adc_ready) begin
            adc_data_l_d = left_hold_q;
            adc_data_r_d = pack_word(word);
            adc_valid_d  = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
    end else if (rx_cnt_q != CNT_IDLE) begin
      rx_cnt_d = rx_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge aud_bclk or negedge sys_rst) begin
    if (!sys_rst) begin
      lrc_d0_q     <= 1'b0;
      rx_cnt_q     <= CNT_IDLE;
      ch_q         <= CH_LEFT;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_held_q  <= 1'b0;
      adc_data_l_q <= '0;
      adc_data_r_q <= '0;
      adc_valid_q  <= 1'b0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      lrc_d0_q     <= lrc_d0_d;
      rx_cnt_q     <= rx_cnt_d;
      ch_q         <= ch_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      left_held_q  <= left_held_d;
      adc_data_l_q <= adc_data_l_d;
      adc_data_r_q <= adc_data_r_d;
      adc_valid_q  <= adc_valid_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign adc_data_l = adc_data_l_q;
  assign adc_data_r = adc_data_r_q;
  assign adc_valid  = adc_valid_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_receive.sv
// Directed testbench for audio_receive: a WL=32 instance and a WL=16
// instance share the serial stimulus; each phase checks the relevant one.

module tb_audio_receive;

  logic        aud_bclk;
  logic        sys_rst;
  logic        aud_lrc;
  logic        aud_adcdat;
  logic        adc_ready;

  logic [31:0] l32, r32, l16, r16;
  logic        v32, v16, done32, done16, fe32, fe16, ov32, ov16;

  int checks = 0;
  int errors = 0;

  // Observation counters, sampled on the falling edge.
  int          n_done = 0;
  int          n_fe   = 0;
  int          n_vhi  = 0;
  int          n_v16  = 0;
  logic [31:0] cap_l   = '0;
  logic [31:0] cap_r   = '0;
  logic [31:0] cap16_l = '0;
  logic [31:0] cap16_r = '0;

  int b_done, b_fe, b_vhi, b_v16;

  audio_receive #(.WL(6'd32)) u_dut32 (
    .aud_bclk   (aud_bclk),
    .sys_rst    (sys_rst),
    .aud_lrc    (aud_lrc),
    .aud_adcdat (aud_adcdat),
    .adc_data_l (l32),
    .adc_data_r (r32),
    .adc_valid  (v32),
    .adc_ready  (adc_ready),
    .rx_done    (done32),
    .frame_err  (fe32),
    .overrun    (ov32)
  );

  audio_receive #(.WL(6'd16)) u_dut16 (
    .aud_bclk   (aud_bclk),
    .sys_rst    (sys_rst),
    .aud_lrc    (aud_lrc),
    .aud_adcdat (aud_adcdat),
    .adc_data_l (l16),
    .adc_data_r (r16),
    .adc_valid  (v16),
    .adc_ready  (adc_ready),
    .rx_done    (done16),
    .frame_err  (fe16),
    .overrun    (ov16)
  );

  initial aud_bclk = 1'b0;
  always #5 aud_bclk = ~aud_bclk;

  always @(negedge aud_bclk) begin
    if (done32) n_done++;
    if (fe32)   n_fe++;
    if (v32) begin
      n_vhi++;
      cap_l = l32;
      cap_r = r32;
    end
    if (v16) begin
      n_v16++;
      cap16_l = l16;
      cap16_r = r16;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One channel slot: cycle 0 carries the lrc edge (data there is the delay
  // bit, driven 1 so a wrong capture shows up), cycles 1..wl carry the word
  // MSB first, later cycles are driven 1 and must be ignored.
  task automatic send_slot(input logic lrc, input logic [31:0] w, input int wl, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge aud_bclk);
      aud_lrc    = lrc;
      aud_adcdat = (i >= 1 && i <= wl) ? w[wl-i] : 1'b1;
    end
  endtask

  task automatic idle(input logic lrc, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aud_bclk);
      aud_lrc    = lrc;
      aud_adcdat = 1'b0;
    end
  endtask

  // Single-cycle high on aud_lrc arms the capture counter without a
  // completed or partial word; the following low starts a left word.
  task automatic sync_pulse();
    @(negedge aud_bclk);
    aud_lrc = 1'b1;
  endtask

  task automatic settle();
    @(negedge aud_bclk);
    #2;
  endtask

  task automatic snap();
    b_done = n_done;
    b_fe   = n_fe;
    b_vhi  = n_vhi;
    b_v16  = n_v16;
  endtask

  task automatic do_reset();
    @(negedge aud_bclk);
    sys_rst = 1'b0;
    aud_lrc = 1'b0;
    aud_adcdat = 1'b0;
    repeat (3) @(negedge aud_bclk);
    sys_rst = 1'b1;
  endtask

  initial begin
    sys_rst    = 1'b0;
    aud_lrc    = 1'b0;
    aud_adcdat = 1'b0;
    adc_ready  = 1'b1;
    #2;

    // Reset values (checked asynchronously, before any clock edge).
    check("rst_data_l", l32, 32'h0);
    check("rst_data_r", r32, 32'h0);
    check("rst_valid", {31'd0, v32}, 32'd0);
    check("rst_rx_done", {31'd0, done32}, 32'd0);
    check("rst_frame_err", {31'd0, fe32}, 32'd0);
    check("rst_overrun", {31'd0, ov32}, 32'd0);

    // Phase 1: basic L/R pair, WL=32, ready held high.
    do_reset();
    snap();
    sync_pulse();
    send_slot(1'b0, 32'h8000_0001, 32, 34);
    send_slot(1'b1, 32'h7FFF_FFFE, 32, 34);
    idle(1'b1, 4);
    settle();
    check("p1_rx_done_cycles", 32'(n_done - b_done), 32'd2);
    check("p1_frame_err_cycles", 32'(n_fe - b_fe), 32'd0);
    check("p1_valid_cycles", 32'(n_vhi - b_vhi), 32'd1);
    check("p1_data_l", cap_l, 32'h8000_0001);
    check("p1_data_r", cap_r, 32'h7FFF_FFFE);
    check("p1_valid_low", {31'd0, v32}, 32'd0);

    // Phase 2: ready low across two frames -> overrun, first pair held.
    adc_ready = 1'b0;
    send_slot(1'b0, 32'hA5A5_0001, 32, 34);
    send_slot(1'b1, 32'h0000_1111, 32, 34);
    idle(1'b1, 2);
    settle();
    check("p2_valid_first", {31'd0, v32}, 32'd1);
    check("p2_overrun_first", {31'd0, ov32}, 32'd0);
    send_slot(1'b0, 32'h1357_9BDF, 32, 34);
    send_slot(1'b1, 32'h2468_ACE0, 32, 34);
    idle(1'b1, 2);
    settle();
    check("p2_overrun", {31'd0, ov32}, 32'd1);
    check("p2_valid_held", {31'd0, v32}, 32'd1);
    check("p2_data_l_held", l32, 32'hA5A5_0001);
    check("p2_data_r_held", r32, 32'h0000_1111);
    adc_ready = 1'b1;
    settle();
    check("p2_valid_drop", {31'd0, v32}, 32'd0);
    check("p2_overrun_sticky", {31'd0, ov32}, 32'd1);

    // Phase 3: left word cut after 20 bits.
    do_reset();
    settle();
    check("p3_overrun_cleared", {31'd0, ov32}, 32'd0);
    snap();
    sync_pulse();
    send_slot(1'b0, 32'hFFFF_FFFF, 32, 21);
    send_slot(1'b1, 32'h0F0F_0F0F, 32, 34);
    idle(1'b1, 4);
    settle();
    check("p3_frame_err_cycles", 32'(n_fe - b_fe), 32'd1);
    check("p3_rx_done_cycles", 32'(n_done - b_done), 32'd1);
    check("p3_no_valid", 32'(n_vhi - b_vhi), 32'd0);

    // Phase 4: stream starts in the right channel.
    do_reset();
    snap();
    send_slot(1'b1, 32'hDEAD_BEEF, 32, 34);
    send_slot(1'b0, 32'h1234_5678, 32, 34);
    send_slot(1'b1, 32'h9ABC_DEF0, 32, 34);
    idle(1'b1, 4);
    settle();
    check("p4_rx_done_cycles", 32'(n_done - b_done), 32'd3);
    check("p4_valid_cycles", 32'(n_vhi - b_vhi), 32'd1);
    check("p4_data_l", cap_l, 32'h1234_5678);
    check("p4_data_r", cap_r, 32'h9ABC_DEF0);

    // Phase 5: reset at bit 10 of a right word while valid is high.
    do_reset();
    adc_ready = 1'b0;
    sync_pulse();
    send_slot(1'b0, 32'h0000_00AA, 32, 34);
    send_slot(1'b1, 32'h0000_0055, 32, 34);
    send_slot(1'b0, 32'h1111_1111, 32, 34);
    send_slot(1'b1, 32'h2222_2222, 32, 11);
    settle();
    check("p5_valid_before", {31'd0, v32}, 32'd1);
    sys_rst = 1'b0;
    #1;
    check("p5_rst_valid", {31'd0, v32}, 32'd0);
    check("p5_rst_data_l", l32, 32'h0);
    check("p5_rst_data_r", r32, 32'h0);
    check("p5_rst_overrun", {31'd0, ov32}, 32'd0);
    check("p5_rst_flags", {30'd0, done32, fe32}, 32'd0);
    adc_ready = 1'b1;
    @(negedge aud_bclk);
    aud_lrc = 1'b0;
    sys_rst = 1'b1;
    snap();
    for (int i = 0; i < 40; i++) begin
      @(negedge aud_bclk);
      aud_lrc    = 1'b0;
      aud_adcdat = 1'(i);
    end
    settle();
    check("p5_no_rx_done", 32'(n_done - b_done), 32'd0);
    send_slot(1'b1, 32'h3333_3333, 32, 34);
    idle(1'b1, 2);
    settle();
    check("p5_rx_done_after_edge", 32'(n_done - b_done), 32'd1);
    check("p5_no_valid", 32'(n_vhi - b_vhi), 32'd0);

    // Phase 6: WL=16 packing in 32-bit slots.
    do_reset();
    snap();
    sync_pulse();
    send_slot(1'b0, 32'h0000_FFFE, 16, 32);
    send_slot(1'b1, 32'h0000_1234, 16, 32);
    idle(1'b1, 4);
    settle();
    check("p6_valid16_cycles", 32'(n_v16 - b_v16), 32'd1);
`ifdef AUD_RX_SIGN_EXT_EN
    check("p6_data16_l", cap16_l, 32'hFFFF_FFFE);
`else
    check("p6_data16_l", cap16_l, 32'h0000_FFFE);
`endif
    check("p6_data16_r", cap16_r, 32'h0000_1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_receive.md
Name: audio_receive

Overview:
I2S capture block for the WM8978 ADC path, on the receive side of the codec interface. It deserialises aud_adcdat, MSB first, in the aud_bclk domain and assembles left/right words into a stereo pair. The pair is presented to user logic through a valid/ready handshake, with overrun and short-frame error reporting. It sits beside the DAC-side serialiser and shares the same aud_bclk/aud_lrc pins.

Parameters:
WL, 6'd32, word length in bits per channel; legal range 16..32.

Ports:
aud_bclk  input  1  bit clock from WM8978; the only clock, all logic on its rising edge.
sys_rst  input  1  asynchronous active-low reset.
aud_lrc  input  1  left/right sync; low = left channel, high = right channel.
aud_adcdat  input  1  serial ADC data from WM8978.
adc_data_l  output  32  left sample, packed per Behaviour.
adc_data_r  output  32  right sample, packed per Behaviour.
adc_valid  output  1  stereo pair available.
adc_ready  input  1  user accepts the pair when adc_valid && adc_ready.
rx_done  output  1  one-cycle pulse per completed channel word (L or R).
frame_err  output  1  one-cycle pulse when a word is cut short by an aud_lrc edge.
overrun  output  1  sticky flag: a completed pair was dropped because adc_valid was still high.

Behaviour:
- Reset values: all outputs 0; internal lrc_d0 = 0; rx_cnt = 6'd63 (idle, so no capture until the first aud_lrc edge); left-held flag = 0.
- lrc_d0 <= aud_lrc every cycle. lrc_edge = aud_lrc ^ lrc_d0.
- On a cycle with lrc_edge:
  - rx_cnt <= 0.
  - ch <= aud_lrc (channel of the new word).
  - The data bit sampled on this edge is ignored (I2S one-bit delay).
  - If the previous rx_cnt was in 1..WL-1, pulse frame_err on the next cycle and discard the partial word.
- Otherwise, when rx_cnt < WL: shift_reg <= {shift_reg, aud_adcdat} and rx_cnt++.
- Otherwise rx_cnt increments, saturating at 63. Bits beyond WL are ignored.
- Word complete: on the edge where rx_cnt goes WL-1 -> WL. rx_done is high for the following cycle (1 cycle latency after the last bit).
- Word packing: bits [WL-1:0] hold the word, MSB = first bit received. Upper bits per Optional Feature.
- Left word complete (ch = 0):
  - Store into the left holding register.
  - Set left-held.
- Right word complete (ch = 1) with left-held = 1:
  - If adc_valid = 0 (or adc_valid && adc_ready in that same cycle): load adc_data_l/adc_data_r, adc_valid <= 1 in the same cycle rx_done rises, clear left-held.
  - Else: drop the pair, overrun <= 1, clear left-held. The old outputs stay stable.
- Right word complete with left-held = 0 (stream started mid-frame): the word is discarded, no valid, no error.
- frame_err on a left word clears left-held.
- Handshake rules:
  - adc_valid falls in the cycle after adc_valid && adc_ready.
  - adc_data_l/adc_data_r are stable while adc_valid = 1.
  - adc_ready is ignored while adc_valid = 0.
- overrun clears only on reset.
- Reset mid-word or mid-handshake: immediate return to reset values. The partial word is lost and capture resumes at the next aud_lrc edge.

Optional Feature:
AUD_RX_SIGN_EXT_EN
- Defined: bits [31:WL] of adc_data_l/adc_data_r replicate bit WL-1 (two's-complement sign extension).
- Undefined: bits [31:WL] are zero.
- With WL = 32 both builds are identical.

Test Plan:
- Reset release with aud_lrc = 0, then L = 32'h8000_0001, R = 32'h7FFF_FFFE, WL = 32, adc_ready = 1 -> two rx_done pulses; adc_valid pulses once with adc_data_l = 32'h8000_0001, adc_data_r = 32'h7FFF_FFFE.
- WL = 16, L = 16'hFFFE, R = 16'h1234 in 32-bit slots -> without macro adc_data_l = 32'h0000_FFFE; with AUD_RX_SIGN_EXT_EN adc_data_l = 32'hFFFF_FFFE; adc_data_r = 32'h0000_1234 in both builds.
- adc_ready held 0 across two full stereo frames -> first pair held stable, overrun = 1 after the second right word, outputs unchanged; assert adc_ready -> adc_valid drops the next cycle.
- aud_lrc toggled after 20 bits of a left word (WL = 32) -> frame_err one-cycle pulse, no rx_done for that word, no adc_valid for that frame.
- Stream starts in the right channel (aud_lrc rises first) -> right word discarded, first adc_valid only after the next complete L+R pair.
- sys_rst asserted at bit 10 of a right word with adc_valid = 1 -> all outputs 0 immediately; after release, no rx_done until an aud_lrc edge followed by WL bits.
